pdm_sigma_delta_tx: RTL and testbench

- PCM-to-PDM transmitter; the transmit counterpart of the microphone CIC decimator.
- Takes 18-bit signed PCM samples at 6 kHz via a valid/ready handshake and buffers them in a 2-entry FIFO.
- Runs a second-order sigma-delta modulator at 3 MHz on each sample, held for OSR modulator steps.
- Drives a 1-bit PDM stream plus its bit clock to an external DAC or RC filter pin; runs on the 90 MHz system clock.

---
 rtl/pdm_tx_pkg.sv | 35 +++
 rtl/pdm_sigma_delta_tx_if.sv | 29 ++
 rtl/pdm_sigma_delta_tx_sdm2_core.sv | 46 ++++
 rtl/pdm_sigma_delta_tx.sv | 136 +++++++++++++
 tb/tb_pdm_sigma_delta_tx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pdm_tx_pkg.sv
// ============================================================================
// Module   : pdm_tx_pkg
// Brief    : Shared widths, full-scale constants and integrator saturation
//            for the PCM-to-PDM transmitter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pdm_tx_pkg;

    localparam int IN_W  = 18;
    localparam int ACC_W = 24;
    // Two guard bits hold integrator + input + feedback before clamping.
    localparam int EXT_W = ACC_W + 2;

    typedef logic signed [IN_W-1:0]  sample_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [EXT_W-1:0] ext_t;

    localparam ext_t FS      = EXT_W'(2 ** (IN_W - 1));
    localparam ext_t ACC_MAX = EXT_W'(2 ** (ACC_W - 1) - 1);
    localparam ext_t ACC_MIN = -(EXT_W'(2 ** (ACC_W - 1)));

    function automatic acc_t saturate(input ext_t v);
        if (v > ACC_MAX) begin
            return ACC_W'(ACC_MAX);
        end else if (v < ACC_MIN) begin
            return ACC_W'(ACC_MIN);
        end
        return ACC_W'(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_sigma_delta_tx_if.sv
// ============================================================================
// Module   : pdm_sigma_delta_tx_if
// Brief    : PCM sample valid/ready handshake into the PDM transmitter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pdm_sigma_delta_tx_if;
    import pdm_tx_pkg::*;

    sample_t i_data;
    logic    i_vld;
    logic    i_rdy;

    modport master (
        output i_data,
        output i_vld,
        input  i_rdy
    );

    modport slave (
        input  i_data,
        input  i_vld,
        output i_rdy
    );

endinterface

`default_nettype wire

// File: rtl/pdm_sigma_delta_tx_sdm2_core.sv
// ============================================================================
// Module   : sdm2_core
// Brief    : Second-order sigma-delta modulator with saturating integrators,
//            advanced one bit per step strobe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sdm2_core
    import pdm_tx_pkg::*;
(
    input  logic    CLK,
    input  logic    RST,
    input  logic    i_step,
    input  sample_t i_x,
    output logic    o_bit
);

    acc_t r_i1;
    acc_t r_i2;
    logic r_bit;
    ext_t w_fb;
    acc_t w_i1_new;
    acc_t w_i2_new;

    assign w_fb     = r_bit ? FS : -FS;
    assign w_i1_new = saturate(ext_t'(r_i1) + ext_t'(i_x) - w_fb);
    assign w_i2_new = saturate(ext_t'(r_i2) + ext_t'(w_i1_new) - w_fb);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_i1  <= '0;
            r_i2  <= '0;
            r_bit <= 1'b0;
        end else if (i_step) begin
            r_i1  <= w_i1_new;
            r_i2  <= w_i2_new;
            r_bit <= ~w_i2_new[ACC_W-1];
        end
    end

    assign o_bit = r_bit;

endmodule

`default_nettype wire

// File: rtl/pdm_sigma_delta_tx.sv
// ============================================================================
// Module   : pdm_sigma_delta_tx
// Brief    : PCM-to-PDM transmitter: 2-entry sample FIFO, bit-clock divider,
//            sample-rate bit counter and second-order modulator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pdm_sigma_delta_tx
    import pdm_tx_pkg::*;
#(
    parameter int CLK_DIV_HALF = 15,
    parameter int OSR          = 500
)(
    input  logic                 CLK,
    input  logic                 RST,
    pdm_sigma_delta_tx_if.slave  bus,
    output logic                 pdm_clk,
    output logic                 pdm_data,
    output logic                 o_underrun,
    output logic [15:0]          o_underrun_cnt
);

    localparam int c_DIV_W = $clog2(CLK_DIV_HALF + 1);
    localparam int c_BIT_W = $clog2(OSR + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV_HALF - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(OSR - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_pclk;
    logic [c_BIT_W-1:0] r_bitcnt;
    sample_t            r_fifo [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_occ;
    sample_t            r_held;
    logic [15:0]        r_ucnt;

    logic    w_step;
    logic    w_boundary;
    logic    w_full;
    logic    w_empty;
    logic    w_push;
    logic    w_pop;
    sample_t w_x;
    logic    w_bit;

    // A step is the cycle whose edge takes the bit clock from high to low.
    assign w_step     = r_pclk && (r_div == c_DIV_LAST);
    assign w_boundary = w_step && (r_bitcnt == c_BIT_LAST);
    assign w_full     = (r_occ == 2'd2);
    assign w_empty    = (r_occ == 2'd0);
    assign w_push     = bus.i_vld && !w_full;
    assign w_pop      = w_boundary && !w_empty;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div  <= '0;
            r_pclk <= 1'b0;
        end else if (r_div == c_DIV_LAST) begin
            r_div  <= '0;
            r_pclk <= ~r_pclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bitcnt <= '0;
        end else if (w_step) begin
            r_bitcnt <= (r_bitcnt == c_BIT_LAST) ? '0 : r_bitcnt + 1'b1;
        end
    end

    // Storage needs no reset: occupancy alone defines what is valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.i_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // On underrun the held sample simply repeats (zero-order hold).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_held <= '0;
            r_ucnt <= '0;
        end else begin
            if (w_pop) begin
                r_held <= r_fifo[r_rd_ptr];
            end
            if (o_underrun && (r_ucnt != 16'hFFFF)) begin
                r_ucnt <= r_ucnt + 16'd1;
            end
        end
    end

    assign w_x = r_held >>> 1;

    sdm2_core u_sdm2_core (
        .CLK    (CLK),
        .RST    (RST),
        .i_step (w_step),
        .i_x    (w_x),
        .o_bit  (w_bit)
    );

    assign bus.i_rdy      = !w_full;
    assign pdm_clk        = r_pclk;
    assign pdm_data       = w_bit;
    assign o_underrun     = w_boundary && w_empty;
    assign o_underrun_cnt = r_ucnt;

endmodule

`default_nettype wire

// File: tb/tb_pdm_sigma_delta_tx.sv
// ============================================================================
// Module   : tb_pdm_sigma_delta_tx
// Brief    : Directed bench for the PCM-to-PDM transmitter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pdm_sigma_delta_tx;
    import pdm_tx_pkg::*;

    localparam int CLK_DIV_HALF = 15;
    localparam int OSR          = 500;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        pdm_clk;
    logic        pdm_data;
    logic        o_underrun;
    logic [15:0] o_underrun_cnt;

    pdm_sigma_delta_tx_if bus();

    pdm_sigma_delta_tx #(
        .CLK_DIV_HALF (CLK_DIV_HALF),
        .OSR          (OSR)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .bus            (bus),
        .pdm_clk        (pdm_clk),
        .pdm_data       (pdm_data),
        .o_underrun     (o_underrun),
        .o_underrun_cnt (o_underrun_cnt)
    );

    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_n   = 0;
    int   ones_tot = 0;
    int   upulses  = 0;
    int   bad_chg  = 0;
    logic prev_pclk  = 1'b0;
    logic prev_pdata = 1'b0;
    bit   mon_en     = 1'b0;

    // Counts pdm_clk falls (steps), ones per step, underrun-high cycles and
    // any pdm_data change outside a falling edge.
    always @(negedge CLK) begin
        if (!mon_en) begin
            step_n   = 0;
            ones_tot = 0;
            upulses  = 0;
        end else begin
            if (prev_pclk && !pdm_clk) begin
                step_n   = step_n + 1;
                ones_tot = ones_tot + int'(pdm_data);
            end else if (pdm_data !== prev_pdata) begin
                bad_chg = bad_chg + 1;
            end
            if (o_underrun) begin
                upulses = upulses + 1;
            end
        end
        prev_pclk  = pdm_clk;
        prev_pdata = pdm_data;
    end

    task automatic check_val(input string tag, input int got, input int lo, input int hi);
        n_checks++;
        if (got >= lo && got <= hi) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic wait_step(input int n);
        int g;
        int lim;
        g   = 0;
        lim = (n - step_n + 2) * 2 * CLK_DIV_HALF;
        while (step_n < n && g < lim) begin
            @(negedge CLK);
            g++;
        end
        if (step_n < n) begin
            check_val("step_timeout", step_n, n, n);
        end
    endtask

    task automatic cycles_until(input logic lvl, output int n);
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (pdm_clk !== lvl && n < 100);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_pclk"},  int'(pdm_clk),     0, 0);
        check_val({pfx, "_pdata"}, int'(pdm_data),    0, 0);
        check_val({pfx, "_urun"},  int'(o_underrun),  0, 0);
        check_val({pfx, "_ucnt"},  int'(o_underrun_cnt), 0, 0);
        check_val({pfx, "_rdy"},   int'(bus.i_rdy),   1, 1);
    endtask

    initial begin
        int n;
        int g;
        int snap;

        bus.i_vld  = 1'b0;
        bus.i_data = '0;

        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("por");
        RST    = 1'b0;
        mon_en = 1'b1;

        // Bit clock: first rise 15 CLK after release, then 15 high / 15 low.
        cycles_until(1'b1, n);
        check_val("first_rise", n, CLK_DIV_HALF, CLK_DIV_HALF);
        cycles_until(1'b0, n);
        check_val("high_time", n, CLK_DIV_HALF, CLK_DIV_HALF);
        cycles_until(1'b1, n);
        check_val("low_time", n, CLK_DIV_HALF, CLK_DIV_HALF);

        // Idle window 0: 50% density, first underrun at step 500.
        wait_step(500);
        snap = ones_tot;
        check_val("w0_ones", snap, 249, 251);
        check_val("urun_pulses_1", upulses, 1, 1);
        check_val("urun_cnt_1", int'(o_underrun_cnt), 1, 1);

        // Three samples back to back from empty.
        bus.i_vld  = 1'b1;
        bus.i_data = IN_W'(65536);
        check_val("rdy_empty", int'(bus.i_rdy), 1, 1);
        @(posedge CLK);
        #1;
        check_val("rdy_one", int'(bus.i_rdy), 1, 1);
        bus.i_data = IN_W'(-131072);
        @(posedge CLK);
        #1;
        check_val("rdy_full", int'(bus.i_rdy), 0, 0);
        bus.i_data = IN_W'(0);
        g = 0;
        while (!bus.i_rdy && g < 20000) begin
            @(posedge CLK);
            #1;
            g++;
        end
        // Ready returns right after the step-1000 edge, before its fall is counted.
        check_val("rdy_reassert_step", step_n, 999, 999);
        @(posedge CLK);
        #1;
        bus.i_vld = 1'b0;
        check_val("rdy_after_third", int'(bus.i_rdy), 0, 0);

        wait_step(1000);
        check_val("w1_ones", ones_tot - snap, 249, 251);
        check_val("urun_cnt_hold", int'(o_underrun_cnt), 1, 1);
        check_val("urun_pulses_hold", upulses, 1, 1);
        snap = ones_tot;

        // FIFO order: 65536 (62.5%), -131072 (25%), 0 (50%).
        wait_step(1500);
        check_val("wA_ones", ones_tot - snap, 310, 315);
        snap = ones_tot;
        wait_step(2000);
        check_val("wB_ones", ones_tot - snap, 123, 127);
        snap = ones_tot;
        wait_step(2500);
        check_val("wC_ones", ones_tot - snap, 248, 252);
        check_val("urun_cnt_2", int'(o_underrun_cnt), 2, 2);
        check_val("urun_pulses_2", upulses, 2, 2);

        // Fill the FIFO, then reset mid-sample.
        bus.i_vld  = 1'b1;
        bus.i_data = IN_W'(65536);
        @(posedge CLK);
        #1;
        bus.i_data = IN_W'(-65536);
        @(posedge CLK);
        #1;
        bus.i_vld = 1'b0;
        check_val("rdy_prereset", int'(bus.i_rdy), 0, 0);

        wait_step(2600);
        mon_en = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("mid");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        #1;
        mon_en = 1'b1;
        cycles_until(1'b1, n);
        check_val("rst_first_rise", n, CLK_DIV_HALF, CLK_DIV_HALF);

        wait_step(100);
        check_val("rst_ones", ones_tot, 49, 51);
        check_val("rst_urun_pulses", upulses, 0, 0);
        check_val("rst_ucnt", int'(o_underrun_cnt), 0, 0);
        check_val("rst_rdy", int'(bus.i_rdy), 1, 1);
        check_val("data_only_on_fall", bad_chg, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
